// File: rtl/adder_pipe_acc.sv
// Streaming two-operand adder with a configurable pipeline depth, a per-beat
// pairwise/accumulate mode and optional saturating accumulation.
//
// Handshake: a beat is accepted when in_valid && in_ready on a rising clk
// edge; a result transfers when out_valid && out_ready. The pipeline moves
// as a whole: it advances when the output register is empty or being
// drained, and otherwise every stage (and in_ready) freezes.
module adder_pipe_acc #(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned ACC_GUARD = 8,
  parameter bit          SATURATE  = 1'b0,
  localparam int unsigned C_WIDTH  = D_WIDTH + 1 + ACC_GUARD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic               acc_en,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH-1:0] c,
  output logic               ovf
);

  localparam logic [C_WIDTH-1:0] ACC_MAX = '1;

  logic               advance;
  logic               accept;

  // accumulator state; sat_q remembers that the accumulator is pinned at max
  logic [C_WIDTH-1:0] acc_q, acc_d;
  logic               sat_q, sat_d;

  logic [D_WIDTH:0]   pair_sum;
  logic [C_WIDTH:0]   acc_sum;
  logic [C_WIDTH-1:0] res_d;
  logic               ovf_d;

  // pipeline stages; index LATENCY-1 is the output register
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] ovf_q;
  logic [C_WIDTH-1:0] res_q [LATENCY];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  // Result of the beat currently on the inputs, plus the accumulator's next value
  always_comb begin
    pair_sum = {1'b0, a} + {1'b0, b};
    acc_sum  = (acc_clr ? '0 : {1'b0, acc_q})
             + {{(C_WIDTH + 1 - D_WIDTH){1'b0}}, a}
             + {{(C_WIDTH + 1 - D_WIDTH){1'b0}}, b};
    acc_d    = acc_q;
    sat_d    = sat_q;
    ovf_d    = 1'b0;
    res_d    = C_WIDTH'(pair_sum);
    if (acc_en) begin
      if (SATURATE && sat_q && !acc_clr) begin
        // already clamped: stay at max until a clearing beat
        acc_d = ACC_MAX;
        ovf_d = 1'b1;
      end else if (acc_sum[C_WIDTH]) begin
        ovf_d = 1'b1;
        acc_d = SATURATE ? ACC_MAX : acc_sum[C_WIDTH-1:0];
        sat_d = SATURATE;
      end else begin
        acc_d = acc_sum[C_WIDTH-1:0];
        sat_d = 1'b0;
      end
      res_d = acc_d;
    end
  end

  // Accumulator updates at the accept edge so consecutive accumulate beats chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (accept && acc_en) begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  // Pipeline shift; whole pipe holds on a stall, bubbles keep the old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ovf_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        res_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        res_q[0] <= res_d;
        ovf_q[0] <= ovf_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          ovf_q[i] <= ovf_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign c         = res_q[LATENCY-1];
  assign ovf       = ovf_q[LATENCY-1];

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Bench for adder_pipe_acc: three instances share one input stream.
//   0: D_WIDTH=8 LATENCY=3 ACC_GUARD=4 wrap
//   1: D_WIDTH=4 LATENCY=1 ACC_GUARD=0 wrap
//   2: D_WIDTH=4 LATENCY=2 ACC_GUARD=0 saturate
// A queue-based model predicts every result and when it reaches the output.
module tb_adder_pipe_acc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       acc_en = 1'b0;
  logic       acc_clr = 1'b0;
  logic [7:0] a_d = '0;
  logic [7:0] b_d = '0;
  logic [3:0] a4, b4;
  assign a4 = a_d[3:0];
  assign b4 = b_d[3:0];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2;
  logic [12:0] c0;
  logic [4:0]  c1, c2;

  adder_pipe_acc #(.D_WIDTH(8), .LATENCY(3), .ACC_GUARD(4), .SATURATE(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .a(a_d), .b(b_d),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov0), .out_ready(out_ready),
    .c(c0), .ovf(of0));

  adder_pipe_acc #(.D_WIDTH(4), .LATENCY(1), .ACC_GUARD(0), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a4), .b(b4),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov1), .out_ready(out_ready),
    .c(c1), .ovf(of1));

  adder_pipe_acc #(.D_WIDTH(4), .LATENCY(2), .ACC_GUARD(0), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .a(a4), .b(b4),
    .acc_en(acc_en), .acc_clr(acc_clr), .out_valid(ov2), .out_ready(out_ready),
    .c(c2), .ovf(of2));

  logic        ir_w [3];
  logic        ov_w [3];
  logic        of_w [3];
  logic [63:0] c_w  [3];
  assign ir_w[0] = ir0;  assign ir_w[1] = ir1;  assign ir_w[2] = ir2;
  assign ov_w[0] = ov0;  assign ov_w[1] = ov1;  assign ov_w[2] = ov2;
  assign of_w[0] = of0;  assign of_w[1] = of1;  assign of_w[2] = of2;
  assign c_w[0]  = 64'(c0);
  assign c_w[1]  = 64'(c1);
  assign c_w[2]  = 64'(c2);

  // per-instance configuration as seen by the model
  int unsigned cw_p  [3] = '{13, 5, 5};
  int unsigned lat_p [3] = '{3, 1, 2};
  bit          sat_p [3] = '{1'b0, 1'b0, 1'b1};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint c;
    bit     ovf;
    int     steps;   // advancing edges still needed to reach the output
  } exp_t;

  exp_t   exp_q [3][$];
  longint acc_m [3] = '{0, 0, 0};
  bit     sat_m [3] = '{0, 0, 0};

  function automatic void model_beat(input longint av, input longint bv, input bit en,
                                     input bit clr, input int unsigned cw, input bit smode,
                                     inout longint acc, inout bit sat,
                                     output longint res, output bit o);
    longint maxv;
    longint s;
    maxv = (longint'(1) << cw) - 1;
    o    = 1'b0;
    if (!en) begin
      res = av + bv;
    end else begin
      s = (clr ? 0 : acc) + av + bv;
      if (smode && sat && !clr) begin
        acc = maxv;
        o   = 1'b1;
      end else if (s > maxv) begin
        o = 1'b1;
        if (smode) begin
          acc = maxv;
          sat = 1'b1;
        end else begin
          acc = s % (maxv + 1);
        end
      end else begin
        acc = s;
        sat = 1'b0;
      end
      res = acc;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          exp_q[k].delete();
          acc_m[k] = 0;
          sat_m[k] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          bit     ev, adv, mo;
          longint mc, av, bv;
          exp_t   e;
          ev  = exp_q[k].size() > 0 && exp_q[k][0].steps == 0;
          adv = !ev || out_ready;
          if (ev && out_ready) void'(exp_q[k].pop_front());
          if (adv) begin
            foreach (exp_q[k][j]) if (exp_q[k][j].steps > 0) exp_q[k][j].steps--;
            if (in_valid) begin
              av = (k == 0) ? longint'(a_d) : longint'(a_d[3:0]);
              bv = (k == 0) ? longint'(b_d) : longint'(b_d[3:0]);
              model_beat(av, bv, acc_en, acc_clr, cw_p[k], sat_p[k], acc_m[k], sat_m[k], mc, mo);
              e.c     = mc;
              e.ovf   = mo;
              e.steps = int'(lat_p[k]) - 1;
              exp_q[k].push_back(e);
            end
          end
        end
      end
    end
  end

  // ---------------- scoreboard compare + transfer log ----------------
  longint got_c [3][$];
  bit     got_o [3][$];

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit ev;
        ev = exp_q[k].size() > 0 && exp_q[k][0].steps == 0;
        check("in_ready", k, 64'(ir_w[k]), 64'(!ev || out_ready));
        check("out_valid", k, 64'(ov_w[k]), 64'(ev));
        if (ev) begin
          check("c", k, c_w[k], 64'(exp_q[k][0].c));
          check("ovf", k, 64'(of_w[k]), 64'(exp_q[k][0].ovf));
          if (out_ready) begin
            got_c[k].push_back(longint'(c_w[k]));
            got_o[k].push_back(of_w[k]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    for (int k = 0; k < 3; k++) begin
      got_c[k].delete();
      got_o[k].delete();
    end
  endtask

  // present one beat and hold it until instance 0 accepts it
  task automatic beat(input logic [7:0] av, input logic [7:0] bv, input logic en,
                      input logic clr);
    bit rdy;
    int n;
    a_d = av; b_d = bv; acc_en = en; acc_clr = clr; in_valid = 1'b1;
    rdy = 1'b0;
    n   = 0;
    while (!rdy) begin
      @(negedge clk);
      rdy = ir_w[0];
      @(posedge clk);
      #1;
      n++;
      if (!rdy && n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout got in_ready=0 expected 1 within 50 cycles");
        rdy = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // reset state
    @(posedge clk); #2;
    check("rst_out_valid", 0, 64'(ov0), 64'd0);
    check("rst_c", 0, 64'(c0), 64'd0);
    check("rst_ovf", 0, 64'(of0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    clear_logs();

    // 1: pairwise with latency pinned on instance 0 (LATENCY=3)
    beat(8'd2, 8'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("lat_edge_n", 0, 64'(ov0), 64'd0);
    @(posedge clk); #1;
    check("lat_edge_n1", 0, 64'(ov0), 64'd0);
    @(posedge clk); #1;
    check("lat_edge_n2", 0, 64'(ov0), 64'd1);
    check("lat_c", 0, 64'(c0), 64'd5);
    beat(8'd0, 8'd0, 1'b0, 1'b0);
    idle(6);
    check("t1_n", 0, 64'(got_c[0].size()), 64'd2);
    check("t1_c0", 0, 64'(got_c[0][0]), 64'd5);
    check("t1_c1", 0, 64'(got_c[0][1]), 64'd0);
    check("t1_ovf", 0, 64'(got_o[0][0]), 64'd0);
    clear_logs();

    // 2: max pairwise sum
    beat(8'd255, 8'd255, 1'b0, 1'b1);
    idle(6);
    check("t2_main", 0, 64'(got_c[0][0]), 64'd510);
    check("t2_ovf", 0, 64'(got_o[0][0]), 64'd0);
    check("t2_small", 1, 64'(got_c[1][0]), 64'd30);
    clear_logs();

    // 3: back-to-back accumulate
    beat(8'd5, 8'd10, 1'b1, 1'b1);
    beat(8'd20, 8'd20, 1'b1, 1'b0);
    beat(8'd1, 8'd0, 1'b1, 1'b0);
    idle(6);
    check("t3_n", 0, 64'(got_c[0].size()), 64'd3);
    check("t3_c0", 0, 64'(got_c[0][0]), 64'd15);
    check("t3_c1", 0, 64'(got_c[0][1]), 64'd55);
    check("t3_c2", 0, 64'(got_c[0][2]), 64'd56);
    check("t3_small", 1, 64'(got_c[1][1]), 64'd23);
    clear_logs();

    // 4: backpressure for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 4; i++) beat(8'(2 * i) >> 1, 8'(i), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(8);
    check("t4_n", 0, 64'(got_c[0].size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t4_c", i, 64'(got_c[0][i]), 64'(2 * i));
    clear_logs();

    // 5: overflow on the 5-bit accumulators (wrap vs clamp, sticky clamp, clear)
    beat(8'd15, 8'd15, 1'b1, 1'b1);
    beat(8'd1, 8'd1, 1'b1, 1'b0);
    beat(8'd0, 8'd0, 1'b1, 1'b0);
    beat(8'd1, 8'd0, 1'b1, 1'b1);
    idle(6);
    check("t5_wrap_c", 1, 64'(got_c[1][1]), 64'd0);
    check("t5_wrap_ovf", 1, 64'(got_o[1][1]), 64'd1);
    check("t5_wrap_after", 1, 64'(got_o[1][2]), 64'd0);
    check("t5_sat_c", 2, 64'(got_c[2][1]), 64'd31);
    check("t5_sat_ovf", 2, 64'(got_o[2][1]), 64'd1);
    check("t5_sat_sticky", 2, 64'(got_o[2][2]), 64'd1);
    check("t5_sat_clr", 2, 64'(got_c[2][3]), 64'd1);
    clear_logs();

    // 6: reset with beats in flight, then accumulate without clear
    beat(8'd3, 8'd3, 1'b1, 1'b1);
    beat(8'd1, 8'd1, 1'b1, 1'b0);
    beat(8'd2, 8'd2, 1'b1, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t6_rst_valid", 0, 64'(ov0), 64'd0);
    check("t6_rst_valid", 1, 64'(ov1), 64'd0);
    check("t6_rst_c", 1, 64'(c1), 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_logs();
    beat(8'd1, 8'd1, 1'b1, 1'b0);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      check("t6_n", k, 64'(got_c[k].size()), 64'd1);
      check("t6_c", k, 64'(got_c[k][0]), 64'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
